// File: rtl/slot_ram_bridge_if.sv
// ---------------------------------------------------------------------------
// slot_ram_bridge_if
//   SDRAM request/acknowledge bus between slot_ram_bridge and the SDRAM
//   controller. One level request, held until a single-cycle ack.
//
//   sdram_req    bridge -> sdram   request, level, held until ack
//   sdram_we     bridge -> sdram   1 = write, 0 = read (valid with req)
//   sdram_addr   bridge -> sdram   byte address (valid with req)
//   sdram_wdata  bridge -> sdram   write data (valid with req)
//   sdram_ack    sdram -> bridge   one-cycle completion pulse
//   sdram_rdata  sdram -> bridge   read data, valid in the ack cycle
//
//   modport master : the bridge (request side)
//   modport slave  : the SDRAM controller (response side)
// ---------------------------------------------------------------------------
interface slot_ram_bridge_if #(
  parameter int ADDR_W = 27
);
  logic              sdram_req;
  logic              sdram_we;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_wdata;
  logic              sdram_ack;
  logic [7:0]        sdram_rdata;

  modport master (
    output sdram_req,
    output sdram_we,
    output sdram_addr,
    output sdram_wdata,
    input  sdram_ack,
    input  sdram_rdata
  );

  modport slave (
    input  sdram_req,
    input  sdram_we,
    input  sdram_addr,
    input  sdram_wdata,
    output sdram_ack,
    output sdram_rdata
  );
endinterface

// File: rtl/slot_ram_bridge.sv
// ---------------------------------------------------------------------------
// slot_ram_bridge
//   Turns each CPU memory cycle decoded by a slot mapper into at most one
//   SDRAM request. The CPU is stalled with cpu_wait until the SDRAM acks.
//   A one-entry read cache lets repeated reads of the same byte (polling
//   loops) complete without touching SDRAM. A timeout forces completion if
//   the ack never arrives and latches a sticky error flag.
//
// Parameters
//   ADDR_W   width of the mapped / SDRAM byte address
//   TIMEOUT  max cycles spent waiting for ack before forced completion (>=2)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   mreq         CPU memory request, held for the whole CPU cycle
//   rd, wr       CPU read / write strobes (wr wins if both high)
//   cpu_wdata    CPU write data
//   ram_cs       mapper chip select
//   ram_addr     mapper address
//   flush        invalidate the read cache
//   cpu_wait     stall CPU while an SDRAM access is outstanding
//   cpu_rdata    read data returned to the CPU
//   sdram        SDRAM request bus (master side)
//   err_timeout  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module slot_ram_bridge #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mreq,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  ram_cs,
  input  logic [ADDR_W-1:0]     ram_addr,
  input  logic                  flush,
  output logic                  cpu_wait,
  output logic [7:0]            cpu_rdata,
  slot_ram_bridge_if.master     sdram,
  output logic                  err_timeout
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;

  logic              sdram_req_reg;
  logic              sdram_we_reg;
  logic [ADDR_W-1:0] sdram_addr_reg;
  logic [7:0]        sdram_wdata_reg;
  logic [7:0]        cpu_rdata_reg;
  logic              err_timeout_reg;
  logic [CNT_W-1:0]  counter_reg;

  logic              cache_valid_reg;
  logic [ADDR_W-1:0] cache_tag_reg;
  logic [7:0]        cache_data_reg;

  logic              start;
  logic              hit;
  logic              timeout_fire;

  // A new access is accepted only from IDLE; DONE waits for mreq to drop,
  // so a held mreq produces exactly one access.
  assign start = mreq & ram_cs & (rd | wr) & (state_reg == ST_IDLE);

  // A simultaneous rd+wr is treated as a write, so it must never be
  // satisfied from the cache.
  assign hit = rd & ~wr & cache_valid_reg & (ram_addr == cache_tag_reg);

  // Ack in the final counted cycle takes precedence over the timeout.
  assign timeout_fire = (counter_reg == CNT_LAST) & ~sdram.sdram_ack;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    // Wait is raised in the start cycle itself so the CPU never samples
    // stale data; held low while reset is asserted.
    cpu_wait   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (hit) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_BUSY;
            cpu_wait   = reset_n;
          end
        end
      end
      ST_BUSY: begin
        cpu_wait = reset_n;
        if (sdram.sdram_ack || timeout_fire) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!mreq) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: SDRAM request registers, read data, cache, timeout counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdram_req_reg   <= 1'b0;
      sdram_we_reg    <= 1'b0;
      sdram_addr_reg  <= '0;
      sdram_wdata_reg <= 8'h00;
      cpu_rdata_reg   <= 8'hFF;
      err_timeout_reg <= 1'b0;
      counter_reg     <= '0;
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_data_reg  <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (hit) begin
              cpu_rdata_reg <= cache_data_reg;
            end else begin
              sdram_req_reg   <= 1'b1;
              sdram_we_reg    <= wr;
              sdram_addr_reg  <= ram_addr;
              sdram_wdata_reg <= cpu_wdata;
              counter_reg     <= '0;
            end
          end
        end
        ST_BUSY: begin
          counter_reg <= counter_reg + CNT_W'(1);
          if (sdram.sdram_ack) begin
            sdram_req_reg <= 1'b0;
            if (!sdram_we_reg) begin
              // Read fill: result also becomes the cached byte.
              cpu_rdata_reg   <= sdram.sdram_rdata;
              cache_tag_reg   <= sdram_addr_reg;
              cache_data_reg  <= sdram.sdram_rdata;
              cache_valid_reg <= 1'b1;
            end else if (cache_valid_reg && (cache_tag_reg == sdram_addr_reg)) begin
              // Write-through keeps the cached byte coherent.
              cache_data_reg <= sdram_wdata_reg;
            end
          end else if (timeout_fire) begin
            sdram_req_reg   <= 1'b0;
            cpu_rdata_reg   <= 8'hFF;
            err_timeout_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      // Placed last so a flush beats a fill arriving in the same cycle.
      if (flush) begin
        cache_valid_reg <= 1'b0;
      end
    end
  end

  assign sdram.sdram_req   = sdram_req_reg;
  assign sdram.sdram_we    = sdram_we_reg;
  assign sdram.sdram_addr  = sdram_addr_reg;
  assign sdram.sdram_wdata = sdram_wdata_reg;
  assign cpu_rdata         = cpu_rdata_reg;
  assign err_timeout       = err_timeout_reg;

endmodule
